// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// FIFO_UART_PARITY_EN adds the PARITY state to the state encoding.
package fifo_uart_pkg;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

`ifdef FIFO_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Down-counting baud divider: tick on the terminal count of each bit period.
// load presets the count to CLKS_PER_BIT-1; it then reloads itself on reaching 0.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a registered-read FIFO and serializes them LSB first.
// Define FIFO_UART_PARITY_EN to append an even parity bit between data and stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifoisempty,
    input  logic [WIDTH-1:0] Data_in,
    output logic             o_rreq,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic [IDX_W-1:0] bit_idx;
    logic             tick;
    logic             cnt_load;
    logic             cnt_en;
    logic             rst_done;
`ifdef FIFO_UART_PARITY_EN
    logic             par_bit;
`endif

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .tick  (tick)
    );

    assign sh_next  = shreg >> 1;
    assign cnt_load = (state == FETCH);
    assign cnt_en   = (state != IDLE) && (state != FETCH);
    assign busy     = (state != IDLE);
    assign tx_done  = (state == STOP) && tick;
    // The read strobe must coincide with the decision cycle so FETCH sees the FIFO's registered data.
    assign o_rreq   = rst_done && !fifoisempty && ((state == IDLE) || tx_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef FIFO_UART_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (o_rreq) state <= FETCH;
                end
                FETCH: begin
                    shreg   <= Data_in;
                    bit_idx <= '0;
`ifdef FIFO_UART_PARITY_EN
                    par_bit <= ^Data_in;
`endif
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef FIFO_UART_PARITY_EN
                            tx    <= par_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shreg   <= sh_next;
                            tx      <= sh_next[0];
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
`ifdef FIFO_UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state <= o_rreq ? FETCH : IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small registered-read FIFO model; CLKS_PER_BIT=4.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int W   = 8;
`ifdef FIFO_UART_PARITY_EN
    localparam int FB  = W + 3;
`else
    localparam int FB  = W + 2;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         fifoisempty;
    logic [W-1:0] Data_in;
    logic         o_rreq;
    logic         tx;
    logic         busy;
    logic         tx_done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] fifo_q[$];
    bit           toggle_en;
    logic [127:0] tr_tx, tr_rreq, tr_busy, tr_done;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifoisempty (fifoisempty),
        .Data_in     (Data_in),
        .o_rreq      (o_rreq),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Trace index c is the clock period whose outputs are sampled at its falling edge.
    task automatic run_cycles(input int n);
        logic rd;
        tr_tx   = '1;
        tr_rreq = '0;
        tr_busy = '0;
        tr_done = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tr_tx[c]   = tx;
            tr_rreq[c] = o_rreq;
            tr_busy[c] = busy;
            tr_done[c] = tx_done;
            rd = o_rreq;
            @(posedge clk);
            #1;
            if (rd) begin
                if (fifo_q.size() > 0) Data_in = fifo_q.pop_front();
                else Data_in = 8'hEE;
            end else if (toggle_en) begin
                Data_in = W'($urandom_range(0, 255));
            end
            fifoisempty = (fifo_q.size() == 0);
        end
    endtask

    function automatic logic [127:0] frame_tx(input logic [127:0] base, input logic [W-1:0] w, input int s);
        logic [127:0] v;
        v = base;
        for (int i = 0; i < CPB; i++) begin
            v[s + i] = 1'b0;
            for (int b = 0; b < W; b++) v[s + CPB * (1 + b) + i] = w[b];
`ifdef FIFO_UART_PARITY_EN
            v[s + CPB * (1 + W) + i] = ^w;
`endif
        end
        return v;
    endfunction

    function automatic logic [127:0] span(input int a, input int b);
        logic [127:0] v;
        v = '0;
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        reset       = 1'b1;
        fifoisempty = 1'b0;
        Data_in     = '0;
        toggle_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (o_rreq !== 1'b0) begin failures++; $display("FAIL reset_rreq got=%b exp=0", o_rreq); end
        checks++;
        if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        reset = 1'b0;
        #1;
        checks++;
        if (o_rreq !== 1'b0) begin failures++; $display("FAIL rreq_before_first_edge got=%b exp=0", o_rreq); end
        fifoisempty = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle();
        run_cycles(100);
        checks++;
        if (tr_rreq !== '0) begin failures++; $display("FAIL idle_rreq got=%h exp=0", tr_rreq); end
        checks++;
        if (tr_busy !== '0) begin failures++; $display("FAIL idle_busy got=%h exp=0", tr_busy); end
        checks++;
        if (tr_tx !== '1) begin failures++; $display("FAIL idle_tx got=%h exp=all ones", tr_tx); end
        checks++;
        if (tr_done !== '0) begin failures++; $display("FAIL idle_done got=%h exp=0", tr_done); end
    endtask

    task automatic test_frame(input string name, input logic [W-1:0] w, input bit tog);
        int last;
        logic [127:0] e_tx;
        last = 1 + CPB * FB;
        toggle_en = tog;
        fifo_q.push_back(w);
        fifoisempty = 1'b0;
        run_cycles(last + 3);
        toggle_en = 1'b0;
        e_tx = frame_tx('1, w, 2);
        checks++;
        if (tr_tx !== e_tx) begin failures++; $display("FAIL %s_tx got=%h exp=%h", name, tr_tx, e_tx); end
        checks++;
        if (tr_rreq !== span(0, 0)) begin failures++; $display("FAIL %s_rreq got=%h exp=%h", name, tr_rreq, span(0, 0)); end
        checks++;
        if (tr_busy !== span(1, last)) begin failures++; $display("FAIL %s_busy got=%h exp=%h", name, tr_busy, span(1, last)); end
        checks++;
        if (tr_done !== span(last, last)) begin failures++; $display("FAIL %s_done got=%h exp=%h", name, tr_done, span(last, last)); end
    endtask

    task automatic test_back_to_back();
        int last1, s2, last2;
        logic [127:0] e_tx, e_rreq, e_done;
        last1 = 1 + CPB * FB;
        s2    = last1 + 2;
        last2 = s2 + CPB * FB - 1;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifoisempty = 1'b0;
        run_cycles(last2 + 3);
        e_tx   = frame_tx(frame_tx('1, 8'h00, 2), 8'hFF, s2);
        e_rreq = span(0, 0) | span(last1, last1);
        e_done = span(last1, last1) | span(last2, last2);
        checks++;
        if (tr_tx !== e_tx) begin failures++; $display("FAIL b2b_tx got=%h exp=%h", tr_tx, e_tx); end
        checks++;
        if (tr_rreq !== e_rreq) begin failures++; $display("FAIL b2b_rreq got=%h exp=%h", tr_rreq, e_rreq); end
        checks++;
        if (tr_busy !== span(1, last2)) begin failures++; $display("FAIL b2b_busy got=%h exp=%h", tr_busy, span(1, last2)); end
        checks++;
        if (tr_done !== e_done) begin failures++; $display("FAIL b2b_done got=%h exp=%h", tr_done, e_done); end
    endtask

    task automatic test_reset_mid();
        fifo_q.push_back(8'h96);
        fifoisempty = 1'b0;
        run_cycles(2 + CPB * 4 + 2);
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL abort_tx got=%b exp=1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++;
        if (tx_done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", tx_done); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_cycles(8);
        checks++;
        if (tr_done !== '0) begin failures++; $display("FAIL post_abort_done got=%h exp=0", tr_done); end
        checks++;
        if (tr_tx !== '1) begin failures++; $display("FAIL post_abort_tx got=%h exp=all ones", tr_tx); end
        checks++;
        if (tr_rreq !== '0) begin failures++; $display("FAIL post_abort_rreq got=%h exp=0", tr_rreq); end
        test_frame("after_abort", 8'h3C, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame("w_a5", 8'hA5, 1'b0);
        test_frame("w_01", 8'h01, 1'b0);
        test_back_to_back();
        test_reset_mid();
        test_frame("toggle_c3", 8'hC3, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port fifoisempty, input, 1 bit: upstream FIFO empty flag.
REQ-006 SHALL have port Data_in, input, WIDTH bits: upstream FIFO registered read data, valid the cycle after a read request.
REQ-007 SHALL have port o_rreq, output, 1 bit: one-cycle read request to the upstream FIFO.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port tx_done, output, 1 bit: one-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 SHALL implement states IDLE, FETCH, START, DATA, STOP, plus PARITY when FIFO_UART_PARITY_EN is defined.
REQ-012 IDLE: when fifoisempty=0, SHALL assert o_rreq for exactly that cycle and go to FETCH; otherwise SHALL stay in IDLE with tx=1.
REQ-013 FETCH: SHALL capture Data_in into an internal shift register, load the bit counter with CLKS_PER_BIT-1, and go to START; o_rreq=0.
REQ-014 START: SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-015 DATA: SHALL drive WIDTH bits LSB first, each for CLKS_PER_BIT cycles; the bit index wraps from WIDTH-1 to exit.
REQ-016 STOP: SHALL drive tx=1 for CLKS_PER_BIT cycles, and SHALL pulse tx_done on the last of them.
REQ-017 On the last STOP cycle with fifoisempty=0, SHALL assert o_rreq and go directly to FETCH; the line then stays high for one extra cycle between frames.
REQ-018 On the last STOP cycle with fifoisempty=1, SHALL go to IDLE.
REQ-019 o_rreq SHALL never be asserted while fifoisempty=1, and SHALL never be asserted in START, DATA, PARITY or FETCH.
REQ-020 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count down, and reload on reaching 0.
REQ-021 Changes on fifoisempty or Data_in mid-frame SHALL NOT affect the frame in flight.
REQ-022 tx SHALL be registered, with no combinational path from any input.

Reset
REQ-023 While reset=1, SHALL set state=IDLE, tx=1, o_rreq=0, busy=0, tx_done=0, and clear the counters and shift register.
REQ-024 A reset asserted mid-frame SHALL abort the frame immediately (tx=1); the aborted word SHALL NOT be re-sent.
REQ-025 After reset is released, the first o_rreq SHALL occur no earlier than the first rising edge of clk.

Configuration
REQ-026 Macro FIFO_UART_PARITY_EN defined: a PARITY state between DATA and STOP SHALL drive the even parity bit (XOR of all data bits) for CLKS_PER_BIT cycles; frame = WIDTH+3 bits.
REQ-027 Macro FIFO_UART_PARITY_EN undefined: no PARITY state and no parity logic SHALL exist; frame = WIDTH+2 bits.

Structure
REQ-028 Package fifo_uart_pkg SHALL hold the state enum typedef and the default WIDTH and CLKS_PER_BIT constants.
REQ-029 The baud counter SHALL be sub-module uart_baud_cnt (inputs load and en; output tick on terminal count); the FSM and shift register SHALL live in fifo_uart_tx.

Verification
REQ-030 (CLKS_PER_BIT=4, parity off) FIFO holds 0xA5, fifoisempty falls at cycle 0 -> o_rreq=1 at cycle 0, tx low at cycles 2-5, then data bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high, tx_done at cycle 41.
REQ-031 Two words 0x00, 0xFF queued -> o_rreq on the last stop cycle of word 1, exactly 5 high cycles between frames, no IDLE visit, busy high throughout.
REQ-032 fifoisempty held at 1 for 100 cycles -> o_rreq never asserted, tx=1, busy=0.
REQ-033 reset pulsed in the middle of data bit 3 -> tx=1 and busy=0 in the same cycle, no tx_done, next frame starts cleanly from IDLE.
REQ-034 FIFO_UART_PARITY_EN defined, words 0xA5 and 0x01 -> parity bits 0 and 1 respectively, each 4 cycles wide before the stop bit.
REQ-035 Data_in toggled randomly during DATA -> the serialized bits match the word captured in FETCH.
